// File: rtl/score_pkg.sv
// Shared types and constants for the score digit renderer: FSM states, BCD
// digit type, default glyph geometry and the add-3 correction step.
package score_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_COMMIT
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int unsigned GLYPH_W_DEF  = 30;
    localparam int unsigned GLYPH_H_DEF  = 30;
    localparam int unsigned GLYPH_PIXELS = GLYPH_W_DEF * GLYPH_H_DEF;

    function automatic bcd_t add3(input bcd_t d);
        return (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, BIN_W shift
// cycles after start; done stays high until the next start.
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int unsigned BIN_W  = 20,
    parameter int unsigned DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_out
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]    bin_sr;
    logic [DIGITS*4-1:0] bcd;
    logic [DIGITS*4-1:0] adj;
    logic [CNT_W-1:0]    cnt;
    logic                running;

    always_comb begin
        adj = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            adj[i*4 +: 4] = add3(bcd[i*4 +: 4]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_sr  <= '0;
            bcd     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            bin_sr  <= bin_in;
            bcd     <= '0;
            cnt     <= CNT_W'(BIN_W);
            running <= 1'b1;
        end else if (running && (cnt != '0)) begin
            bcd    <= (adj << 1) | {{(DIGITS*4-1){1'b0}}, bin_sr[BIN_W-1]};
            bin_sr <= bin_sr << 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

    assign done    = running && (cnt == '0);
    assign bcd_out = bcd;

endmodule

// File: rtl/score_digit_renderer.sv
// Score-to-glyph renderer: sequential BCD conversion into a display register
// plus a 2-stage pixel pipeline addressing a glyph ROM.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module score_digit_renderer
    import score_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BIN_W      = 20,
    parameter int unsigned GLYPH_W    = GLYPH_W_DEF,
    parameter int unsigned GLYPH_H    = GLYPH_H_DEF,
    parameter int unsigned ROM_AW     = $clog2(10 * GLYPH_PIXELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  score_in,
    input  logic              score_load,
    output logic              busy,
    input  logic [9:0]        org_x,
    input  logic [8:0]        org_y,
    input  logic [9:0]        pix_x,
    input  logic [8:0]        pix_y,
    input  logic              pix_valid,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic              rom_q,
    output logic              pix_on,
    output logic              pix_in_box,
    output logic              pix_valid_out
);

    localparam int unsigned CONV_DIGITS = (BIN_W * 302) / 1000 + 1;
    // Always keep at least one digit above the display so overflow is visible.
    localparam int unsigned ENG_DIGITS  = (CONV_DIGITS > NUM_DIGITS) ? CONV_DIGITS : NUM_DIGITS + 1;
    localparam int unsigned IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FIELD_W     = NUM_DIGITS * GLYPH_W;
    localparam int unsigned GLYPH_AREA  = GLYPH_W * GLYPH_H;

    state_t                  state, state_nx;
    logic                    eng_start, eng_done, commit, overflow;
    logic [BIN_W-1:0]        eng_val, pend_val, pend_val_nx;
    logic                    pend_valid, pend_valid_nx;
    logic [ENG_DIGITS*4-1:0] eng_bcd;
    bcd_t                    disp [NUM_DIGITS];

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (ENG_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (reset),
        .start   (eng_start),
        .bin_in  (eng_val),
        .done    (eng_done),
        .bcd_out (eng_bcd)
    );

    assign overflow = |eng_bcd[ENG_DIGITS*4-1:NUM_DIGITS*4];
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nx      = state;
        eng_start     = 1'b0;
        eng_val       = score_in;
        pend_valid_nx = pend_valid;
        pend_val_nx   = pend_val;
        commit        = 1'b0;
        case (state)
            S_IDLE: begin
                if (score_load) begin
                    eng_start = 1'b1;
                    state_nx  = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (score_load) begin
                    pend_valid_nx = 1'b1;
                    pend_val_nx   = score_in;
                end
                if (eng_done) state_nx = S_COMMIT;
            end
            S_COMMIT: begin
                commit = 1'b1;
                // A load arriving now is newer than any pending value, so it wins.
                if (score_load) begin
                    eng_start     = 1'b1;
                    pend_valid_nx = 1'b0;
                    state_nx      = S_CONVERT;
                end else if (pend_valid) begin
                    eng_start     = 1'b1;
                    eng_val       = pend_val;
                    pend_valid_nx = 1'b0;
                    state_nx      = S_CONVERT;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pend_valid <= 1'b0;
            pend_val   <= '0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) disp[i] <= '0;
        end else begin
            state      <= state_nx;
            pend_valid <= pend_valid_nx;
            pend_val   <= pend_val_nx;
            if (commit) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    disp[i] <= overflow ? 4'd9 : eng_bcd[(NUM_DIGITS-1-i)*4 +: 4];
                end
            end
        end
    end

    logic [NUM_DIGITS-1:0] blank_v;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic zero_run;
    always_comb begin
        blank_v  = '0;
        zero_run = 1'b1;
        for (int unsigned i = 0; i + 1 < NUM_DIGITS; i++) begin
            zero_run   = zero_run && (disp[i] == 4'd0);
            blank_v[i] = zero_run;
        end
    end
`else
    assign blank_v = '0;
`endif

    logic [15:0]       dx, dy, col;
    logic              hit, blank_sel;
    logic [IDX_W-1:0]  idx;
    bcd_t              digit;
    logic [ROM_AW-1:0] addr_nx;

    always_comb begin
        dx  = 16'(pix_x) - 16'(org_x);
        dy  = 16'(pix_y) - 16'(org_y);
        hit = pix_valid && (pix_x >= org_x) && (dx < 16'(FIELD_W))
                        && (pix_y >= org_y) && (dy < 16'(GLYPH_H));
        idx = '0;
        col = dx;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            if (dx >= 16'(i * GLYPH_W)) begin
                idx = IDX_W'(i);
                col = dx - 16'(i * GLYPH_W);
            end
        end
        digit     = disp[idx];
        blank_sel = blank_v[idx];
        addr_nx   = hit ? ROM_AW'(32'(digit) * GLYPH_AREA + 32'(dy) * GLYPH_W + 32'(col)) : '0;
    end

    logic s1_valid, s1_hit, s1_blank, s2_hit, s2_blank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr      <= '0;
            s1_valid      <= 1'b0;
            s1_hit        <= 1'b0;
            s1_blank      <= 1'b0;
            pix_valid_out <= 1'b0;
            s2_hit        <= 1'b0;
            s2_blank      <= 1'b0;
        end else begin
            rom_addr      <= addr_nx;
            s1_valid      <= pix_valid;
            s1_hit        <= hit;
            s1_blank      <= blank_sel;
            pix_valid_out <= s1_valid;
            s2_hit        <= s1_hit;
            s2_blank      <= s1_blank;
        end
    end

    // rom_q arrives in the same cycle as the stage-2 flags.
    assign pix_on     = rom_q & s2_hit & ~s2_blank;
    assign pix_in_box = s2_hit;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Self-checking bench for score_digit_renderer: scoreboard of expected pixel
// results plus direct checks of busy timing and ROM addressing.
module tb_score_digit_renderer;

    localparam int NUM = 6;
    localparam int GW  = 30;
    localparam int GH  = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] score_in = '0;
    logic        score_load = 1'b0;
    logic        busy;
    logic [9:0]  org_x = 10'd100;
    logic [8:0]  org_y = 9'd50;
    logic [9:0]  pix_x = '0;
    logic [8:0]  pix_y = '0;
    logic        pix_valid = 1'b0;
    logic [13:0] rom_addr;
    logic        rom_q = 1'b0;
    logic        pix_on, pix_in_box, pix_valid_out;

    int checks = 0;
    int failures = 0;
    int exp_val = 0;

    typedef struct {
        bit on;
        bit inbox;
        int x;
        int y;
    } exp_t;
    exp_t sb[$];

    score_digit_renderer #(
        .NUM_DIGITS (6),
        .BIN_W      (20),
        .GLYPH_W    (30),
        .GLYPH_H    (30),
        .ROM_AW     (14)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .score_in      (score_in),
        .score_load    (score_load),
        .busy          (busy),
        .org_x         (org_x),
        .org_y         (org_y),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_valid     (pix_valid),
        .rom_addr      (rom_addr),
        .rom_q         (rom_q),
        .pix_on        (pix_on),
        .pix_in_box    (pix_in_box),
        .pix_valid_out (pix_valid_out)
    );

    always #5 clk = ~clk;

    function automatic bit glyph_bit(input int a);
        return a[0] ^ a[2] ^ a[5] ^ a[9];
    endfunction

    always @(posedge clk) rom_q <= glyph_bit(int'(rom_addr));

    function automatic int exp_digit(input int pos);
        int v;
        v = (exp_val > 999999) ? 999999 : exp_val;
        for (int k = 0; k < NUM - 1 - pos; k++) v = v / 10;
        return v % 10;
    endfunction

    function automatic bit exp_blank(input int d);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if (d == NUM - 1) return 1'b0;
        for (int j = 0; j <= d; j++) if (exp_digit(j) != 0) return 1'b0;
        return 1'b1;
`else
        return (d < 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        score_in   = 20'(v);
        score_load = 1'b1;
        tick();
        score_load = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            tick();
            cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, cyc);
        end
    endtask

    task automatic check_rom_digits(input string tag);
        int expa;
        for (int i = 0; i < NUM; i++) begin
            pix_x     = 10'(int'(org_x) + i * GW);
            pix_y     = org_y;
            pix_valid = 1'b1;
            tick();
            expa = exp_digit(i) * GW * GH;
            checks++;
            if (rom_addr !== 14'(expa)) begin
                failures++;
                $display("FAIL %s digit%0d rom_addr: got %0d required %0d", tag, i, rom_addr, expa);
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic scan_frame(input string tag);
        int rows[5] = '{-1, 0, 13, 29, 30};
        int n, x, y, d, a;
        exp_t e;
        pix_valid = 1'b0;
        repeat (3) tick();
        sb.delete();
        n = 5 * 184;
        for (int k = 0; k < n + 3; k++) begin
            if (k < n) begin
                x = int'(org_x) + (k % 184) - 2;
                y = int'(org_y) + rows[k / 184];
                e.x = x;
                e.y = y;
                e.inbox = (x >= int'(org_x)) && (x < int'(org_x) + NUM * GW) &&
                          (y >= int'(org_y)) && (y < int'(org_y) + GH);
                e.on = 1'b0;
                if (e.inbox) begin
                    d = (x - int'(org_x)) / GW;
                    a = exp_digit(d) * GW * GH + (y - int'(org_y)) * GW + (x - int'(org_x)) % GW;
                    e.on = !exp_blank(d) && glyph_bit(a);
                end
                sb.push_back(e);
                pix_x     = 10'(x);
                pix_y     = 9'(y);
                pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
            tick();
            if (pix_valid_out === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected pix_valid_out: got 1 required 0", tag);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (pix_in_box !== e.inbox) begin
                        failures++;
                        $display("FAIL %s pix_in_box (%0d,%0d): got %b required %b", tag, e.x, e.y, pix_in_box, e.inbox);
                    end
                    if (pix_on !== e.on) begin
                        failures++;
                        $display("FAIL %s pix_on (%0d,%0d): got %b required %b", tag, e.x, e.y, pix_on, e.on);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s missing outputs: got %0d pending required 0", tag, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks += 5;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b required 0", busy); end
        if (rom_addr !== 14'd0) begin failures++; $display("FAIL reset rom_addr: got %0d required 0", rom_addr); end
        if (pix_on !== 1'b0) begin failures++; $display("FAIL reset pix_on: got %b required 0", pix_on); end
        if (pix_in_box !== 1'b0) begin failures++; $display("FAIL reset pix_in_box: got %b required 0", pix_in_box); end
        if (pix_valid_out !== 1'b0) begin failures++; $display("FAIL reset pix_valid_out: got %b required 0", pix_valid_out); end
        tick();
        tick();
        reset = 1'b0;
        exp_val = 0;
        check_rom_digits("reset");
    endtask

    task automatic test_load_latency();
        int cnt;
        do_load(123456);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 22) begin
            failures++;
            $display("FAIL busy_cycles: got %0d required 22", cnt);
        end
        exp_val = 123456;
        check_rom_digits("load123456");
        scan_frame("load123456");
    endtask

    task automatic test_leading_zero();
        int cyc;
        do_load(7);
        wait_idle(cyc);
        exp_val = 7;
        scan_frame("load7");
    endtask

    task automatic test_saturate();
        int cyc;
        do_load(1048575);
        wait_idle(cyc);
        exp_val = 1048575;
        check_rom_digits("saturate");
        scan_frame("saturate");
    endtask

    task automatic test_back_to_back();
        int gap, cyc;
        do_load(100);
        gap = 0;
        for (int c = 1; c <= 22; c++) begin
            if (busy !== 1'b1) gap++;
            case (c)
                3: begin score_in = 20'd200; score_load = 1'b1; end
                5: begin score_in = 20'd300; score_load = 1'b1; end
                default: score_load = 1'b0;
            endcase
            tick();
        end
        score_load = 1'b0;
        checks++;
        if (gap != 0) begin
            failures++;
            $display("FAIL b2b busy_gap: got %0d low cycles required 0", gap);
        end
        exp_val = 100;
        check_rom_digits("b2b_first");
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b busy_after_commit: got %b required 1", busy);
        end
        wait_idle(cyc);
        checks++;
        if (cyc != 16) begin
            failures++;
            $display("FAIL b2b second_latency: got %0d required 16", cyc);
        end
        exp_val = 300;
        check_rom_digits("b2b_second");
    endtask

    task automatic test_rom_addr();
        int cyc;
        bit exp_on;
        do_load(50000);
        wait_idle(cyc);
        exp_val = 50000;
        pix_x = 10'd131;
        pix_y = 9'd52;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        checks += 2;
        if (rom_addr !== 14'd4561) begin failures++; $display("FAIL romaddr value: got %0d required 4561", rom_addr); end
        if (pix_valid_out !== 1'b0) begin failures++; $display("FAIL romaddr early_valid: got %b required 0", pix_valid_out); end
        tick();
        exp_on = !exp_blank(1) && glyph_bit(4561);
        checks += 3;
        if (pix_valid_out !== 1'b1) begin failures++; $display("FAIL romaddr valid_out: got %b required 1", pix_valid_out); end
        if (pix_in_box !== 1'b1) begin failures++; $display("FAIL romaddr in_box: got %b required 1", pix_in_box); end
        if (pix_on !== exp_on) begin failures++; $display("FAIL romaddr pix_on: got %b required %b", pix_on, exp_on); end
    endtask

    task automatic test_reset_mid_convert();
        int seen;
        do_load(999);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL midreset busy: got %b required 0", busy); end
        if (pix_on !== 1'b0) begin failures++; $display("FAIL midreset pix_on: got %b required 0", pix_on); end
        if (pix_valid_out !== 1'b0) begin failures++; $display("FAIL midreset pix_valid_out: got %b required 0", pix_valid_out); end
        if (rom_addr !== 14'd0) begin failures++; $display("FAIL midreset rom_addr: got %0d required 0", rom_addr); end
        tick();
        tick();
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL midreset busy_after: got %0d busy cycles required 0", seen); end
        exp_val = 0;
        check_rom_digits("midreset");
        scan_frame("midreset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_latency();
        test_leading_zero();
        test_saturate();
        test_back_to_back();
        test_rom_addr();
        test_reset_mid_convert();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
